// File: rtl/add4_pkg.sv
// add4_pkg: shared types and constants for the nibble-serial adder sequencer.
package add4_pkg;

  // Width of the single adder slice that the sequencer time-shares.
  localparam int NIBBLE_W = 4;

  // Sequencer control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } add4_seq_state_t;

endpackage : add4_pkg

// File: rtl/add4_slice.sv
// add4_slice: purely combinational 4-bit ripple-carry adder slice.
// Besides the carry out of the top bit it exposes the carry into the top bit
// (c3), so a signed overflow flag can be formed as c3 ^ cout on the MSB slice.
module add4_slice
  import add4_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout,
  output logic                c3
);

  logic [NIBBLE_W:0] carry;

  // Bit-level ripple: carry[i] is the carry into bit i.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry[NIBBLE_W];
  assign c3   = carry[NIBBLE_W-1];

endmodule : add4_slice

// File: rtl/add4_sequencer.sv
// add4_sequencer: adds two 4*NIBBLES-bit operands one nibble per clock,
// LSB first, through a single shared add4_slice with the slice carry-out fed
// back as the next carry-in.
//
// Optional feature: define ADD4_SEQ_OVF_EN to add the signed overflow output
// `ovf`. Without it the port and its logic are absent.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no operation in flight; waiting for start
// RUN   | processing nibble idx_q, one nibble per clock edge
// DONE  | result valid for exactly this cycle; start here chains the next op
//
// `sum` is updated nibble by nibble during RUN, so it is only meaningful while
// `done` is high or afterwards while `busy` is low.
module add4_sequencer
  import add4_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          cin,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          cout
`ifdef ADD4_SEQ_OVF_EN
  ,
  output logic                          ovf
`endif
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  add4_seq_state_t state_q, state_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [IDX_W-1:0] idx_q;

  logic                start_ok;
  logic                last_nibble;
  logic [IDX_W+1:0]    bit_base;
  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  // start is only honoured when no operation is in flight.
  assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_nibble = (state_q == RUN) && (idx_q == IDX_LAST);

  // Bit offset of the current nibble inside the operand words.
  assign bit_base = {idx_q, 2'b00};
  assign slice_a  = a_q[bit_base +: NIBBLE_W];
  assign slice_b  = b_q[bit_base +: NIBBLE_W];

`ifdef ADD4_SEQ_OVF_EN
  logic slice_c3;
  logic ovf_q;

  add4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3)
  );
`else
  logic slice_c3_unused;

  add4_slice u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .c3   (slice_c3_unused)
  );
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_nibble) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = start ? RUN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the next state so they can be registered.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_d)
      RUN:     busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Status output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Operand capture, nibble stepping, carry chaining and result delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else if (start_ok) begin
      a_q     <= a;
      b_q     <= b;
      sum_q   <= '0;
      carry_q <= cin;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[bit_base +: NIBBLE_W] <= slice_sum;
      carry_q                     <= slice_cout;
      idx_q                       <= idx_q + 1'b1;
      if (last_nibble) begin
        cout_q <= slice_cout;
      end
    end
  end

`ifdef ADD4_SEQ_OVF_EN
  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (start_ok) begin
      ovf_q <= 1'b0;
    end else if (last_nibble) begin
      ovf_q <= slice_c3 ^ slice_cout;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : add4_sequencer

// File: tb/tb_add4_sequencer.sv
// tb_add4_sequencer: directed, self-checking bench for add4_sequencer with
// NIBBLES=4 (16-bit operands). Define ADD4_SEQ_OVF_EN to also check ovf.
module tb_add4_sequencer;
  import add4_pkg::*;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADD4_SEQ_OVF_EN
  logic         ovf;
`endif

  int total   = 0;
  int bad     = 0;
  int overlap = 0;

  add4_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef ADD4_SEQ_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be high together.
  always @(negedge clk) begin
    if (!rst && busy === 1'b1 && done === 1'b1) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check latency, busy/done shape and the result.
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                    input logic [W-1:0] es, input logic ec, input logic eo);
    int cyc;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_after_accept", 32'(done), 32'd0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (done !== 1'b1) chk("busy_in_run", 32'(busy), 32'd1);
    end
    chk("latency", 32'(cyc), 32'(NIBBLES));
    chk("sum", 32'(sum), 32'(es));
    chk("cout", 32'(cout), 32'(ec));
    chk("busy_in_done", 32'(busy), 32'd0);
`ifdef ADD4_SEQ_OVF_EN
    chk("ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unexpected x in expected ovf");
`endif
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("sum_hold", 32'(sum), 32'(es));
    chk("cout_hold", 32'(cout), 32'(ec));
  endtask

  initial begin
    int cyc;
    int nd;
    logic [W-1:0] got_sum;
    logic         got_cout;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
`ifdef ADD4_SEQ_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Basic sums and full carry ripple.
    op(16'h0001, 16'h0004, 1'b0, 16'h0005, 1'b0, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // start during RUN is ignored.
    @(negedge clk);
    start = 1'b1; a = 16'h0102; b = 16'h0304; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    nd = 0; got_sum = '0; got_cout = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done === 1'b1) begin
        nd++;
        got_sum  = sum;
        got_cout = cout;
      end
      @(posedge clk); #1;
    end
    chk("ignore_done_count", 32'(nd), 32'd1);
    chk("ignore_sum", 32'(got_sum), 32'h0406);
    chk("ignore_cout", 32'(got_cout), 32'd0);

    // Asynchronous reset mid-RUN discards the operation.
    @(negedge clk);
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_state", 32'(dut.state_q), 32'(IDLE));
`ifdef ADD4_SEQ_OVF_EN
    chk("arst_ovf", 32'(ovf), 32'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("arst_hold_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle_busy", 32'(busy), 32'd0);
    op(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Back-to-back: start held in the DONE cycle chains the next operation.
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_first_latency", 32'(cyc), 32'(NIBBLES));
    chk("b2b_first_sum", 32'(sum), 32'h0000);
    chk("b2b_first_cout", 32'(cout), 32'd1);
    start = 1'b1; a = 16'h00F0; b = 16'h0010; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk("b2b_busy_after_done", 32'(busy), 32'd1);
    chk("b2b_done_dropped", 32'(done), 32'd0);
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_done_spacing", 32'(cyc), 32'(NIBBLES + 1));
    chk("b2b_second_sum", 32'(sum), 32'h0101);
    chk("b2b_second_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    chk("b2b_back_to_idle", 32'(done | busy), 32'd0);

    chk("busy_done_overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_add4_sequencer
